// File: rtl/gps_srq_scheduler.sv
// gps_srq_scheduler: latches demodulator epoch requests, picks one channel
// round-robin among unmasked pending requests, runs its serial I/Q readout
// (one load strobe, then IQ_BITS shift strobes) into a parallel word, and
// presents that word to the CPU via a valid/ack handshake.
module gps_srq_scheduler #(
   parameter int NCHAN   = 12,
   parameter int CHAN_W  = 4,
   parameter int IQ_BITS = 48,
   parameter int OVF_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NCHAN-1:0]   chan_srq,
   input  logic [NCHAN-1:0]   chan_mask,
   input  logic               sin,
   output logic [CHAN_W-1:0]  chan_sel,
   output logic               chan_load,
   output logic               chan_shift,
   output logic               out_valid,
   output logic [CHAN_W-1:0]  out_chan,
   output logic [IQ_BITS-1:0] iq_data,
   input  logic               out_ack,
   output logic [NCHAN-1:0]   pending,
   output logic [OVF_W-1:0]   ovf_cnt,
   input  logic               ovf_clr
);

   localparam int CNT_W  = $clog2(IQ_BITS);
   localparam int LOST_W = $clog2(NCHAN + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_SHIFT = 2'd2;
   localparam logic [1:0] S_READY = 2'd3;

   logic [1:0]        state;
   logic [CHAN_W-1:0] rr;
   logic [CHAN_W-1:0] winner;
   logic              found;
   logic              grant;
   logic [NCHAN-1:0]  eligible;
   logic [NCHAN-1:0]  pend_next;
   logic [LOST_W-1:0] lost;
   logic [CNT_W-1:0]  bit_cnt;

   // Saturating add of this cycle's lost requests to the overrun counter.
   function automatic logic [OVF_W-1:0] sat_add(input logic [OVF_W-1:0] a,
                                                input logic [LOST_W-1:0] b);
      logic [OVF_W:0] s;
      s = {1'b0, a} + (OVF_W + 1)'(b);
      if (s[OVF_W]) return '1;
      return s[OVF_W-1:0];
   endfunction

   assign eligible   = pending & chan_mask;
   assign grant      = (state == S_IDLE) && found;
   assign chan_load  = (state == S_LOAD);
   assign chan_shift = (state == S_SHIFT);
   assign out_valid  = (state == S_READY);

   // Round-robin search starting just after the last granted channel, wrapping at NCHAN-1.
   always_comb begin
      int idx;
      logic [CHAN_W-1:0] idx_v;
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      idx_v  = '0;
      for (int off = 1; off <= NCHAN; off++) begin
         idx = int'(rr) + off;
         if (idx >= NCHAN) idx = idx - NCHAN;
         idx_v = CHAN_W'(idx);
         if (!found && eligible[idx_v]) begin
            found  = 1'b1;
            winner = idx_v;
         end
      end
   end

   // Next pending bits; a new request beats the grant clear, a repeat request is an overrun.
   always_comb begin
      logic clr;
      pend_next = '0;
      lost      = '0;
      clr       = 1'b0;
      for (int i = 0; i < NCHAN; i++) begin
         clr          = grant && (winner == CHAN_W'(i));
         pend_next[i] = chan_srq[i] | (pending[i] & ~clr);
         if (chan_srq[i] && pending[i] && !clr) lost = lost + LOST_W'(1);
      end
   end

   // Request latches and overrun counter; clear wins over increment.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= '0;
         ovf_cnt <= '0;
      end else begin
         pending <= pend_next;
         if (ovf_clr)
            ovf_cnt <= '0;
         else if (lost != '0)
            ovf_cnt <= sat_add(ovf_cnt, lost);
      end
   end

   // Service sequencer: grant, load strobe, serial capture (first bit ends in MSB), handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         rr       <= CHAN_W'(NCHAN - 1);
         chan_sel <= '0;
         out_chan <= '0;
         iq_data  <= '0;
         bit_cnt  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (found) begin
                  chan_sel <= winner;
                  rr       <= winner;
                  state    <= S_LOAD;
               end
            end
            S_LOAD: begin
               bit_cnt <= '0;
               state   <= S_SHIFT;
            end
            S_SHIFT: begin
               iq_data <= {iq_data[IQ_BITS-2:0], sin};
               bit_cnt <= bit_cnt + CNT_W'(1);
               if (bit_cnt == CNT_W'(IQ_BITS - 1)) begin
                  out_chan <= chan_sel;
                  state    <= S_READY;
               end
            end
            default: begin
               if (out_ack) state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gps_srq_scheduler.sv
// Directed testbench for gps_srq_scheduler: table of single-channel readouts
// followed by hand-written sequences for arbitration order, masking,
// overrun counting, request/clear collision and reset during readout.
module tb_gps_srq_scheduler;

   localparam int NCHAN   = 12;
   localparam int CHAN_W  = 4;
   localparam int IQ_BITS = 48;
   localparam int OVF_W   = 8;

   logic               clk = 1'b0;
   logic               rst;
   logic [NCHAN-1:0]   chan_srq;
   logic [NCHAN-1:0]   chan_mask;
   logic               sin;
   logic [CHAN_W-1:0]  chan_sel;
   logic               chan_load;
   logic               chan_shift;
   logic               out_valid;
   logic [CHAN_W-1:0]  out_chan;
   logic [IQ_BITS-1:0] iq_data;
   logic               out_ack;
   logic [NCHAN-1:0]   pending;
   logic [OVF_W-1:0]   ovf_cnt;
   logic               ovf_clr;

   gps_srq_scheduler #(
      .NCHAN(NCHAN), .CHAN_W(CHAN_W), .IQ_BITS(IQ_BITS), .OVF_W(OVF_W)
   ) dut (
      .clk(clk), .rst(rst), .chan_srq(chan_srq), .chan_mask(chan_mask), .sin(sin),
      .chan_sel(chan_sel), .chan_load(chan_load), .chan_shift(chan_shift),
      .out_valid(out_valid), .out_chan(out_chan), .iq_data(iq_data), .out_ack(out_ack),
      .pending(pending), .ovf_cnt(ovf_cnt), .ovf_clr(ovf_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  ch;
      logic [47:0] pat;
      logic [47:0] exp_iq;
      logic [3:0]  exp_chan;
      int          exp_lat;
   } vec_t;

   vec_t vt[4];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Waits for the load strobe, feeds the pattern MSB first, checks the captured word.
   task automatic run_service(input logic [3:0] exp_ch, input logic [47:0] pat,
                              input logic [47:0] exp_iq, input bit ack, output int vcyc);
      int w;
      int shifts;
      w = 0;
      while (!chan_load && w < 100) begin
         step();
         w++;
      end
      check("load_seen", 64'(chan_load), 64'(1));
      check("chan_sel", 64'(chan_sel), 64'(exp_ch));
      step();
      shifts = 0;
      for (int k = 0; k < IQ_BITS; k++) begin
         if (chan_shift) shifts++;
         sin = pat[47-k];
         step();
      end
      sin = 1'b0;
      check("shift_count", 64'(shifts), 64'(48));
      check("out_valid", 64'(out_valid), 64'(1));
      vcyc = cyc;
      check("iq_data", 64'(iq_data), 64'(exp_iq));
      check("out_chan", 64'(out_chan), 64'(exp_ch));
      if (ack) begin
         out_ack = 1'b1;
         step();
         out_ack = 1'b0;
         check("valid_drop", 64'(out_valid), 64'(0));
      end
   endtask

   initial begin
      int c0;
      int v;
      int loads;
      int valids;

      vt[0] = '{ch: 4'd0,  pat: 48'hA5A5_0F0F_1234, exp_iq: 48'hA5A5_0F0F_1234, exp_chan: 4'd0,  exp_lat: 51};
      vt[1] = '{ch: 4'd6,  pat: 48'hFFFF_FFFF_FFFF, exp_iq: 48'hFFFF_FFFF_FFFF, exp_chan: 4'd6,  exp_lat: 51};
      vt[2] = '{ch: 4'd11, pat: 48'h0000_0000_0000, exp_iq: 48'h0000_0000_0000, exp_chan: 4'd11, exp_lat: 51};
      vt[3] = '{ch: 4'd9,  pat: 48'h8000_0000_0001, exp_iq: 48'h8000_0000_0001, exp_chan: 4'd9,  exp_lat: 51};

      rst = 1'b1; chan_srq = '0; chan_mask = '1; sin = 1'b0; out_ack = 1'b0; ovf_clr = 1'b0;
      repeat (3) step();
      rst = 1'b0;

      // reset state
      check("rst_pending", 64'(pending), 64'(0));
      check("rst_ovf", 64'(ovf_cnt), 64'(0));
      check("rst_valid", 64'(out_valid), 64'(0));
      check("rst_load", 64'(chan_load), 64'(0));
      check("rst_shift", 64'(chan_shift), 64'(0));
      check("rst_iq", 64'(iq_data), 64'(0));

      // table: single-channel readouts from idle, including exact latency
      for (int i = 0; i < 4; i++) begin
         chan_srq = 12'(1) << vt[i].ch;
         c0 = cyc;
         step();
         chan_srq = '0;
         check("pend_set", 64'(pending[vt[i].ch]), 64'(1));
         run_service(vt[i].exp_chan, vt[i].pat, vt[i].exp_iq, 1'b1, v);
         check("latency", 64'(v - c0), 64'(vt[i].exp_lat));
      end

      // round-robin order after reset: 3,7,11 then 0,3
      rst = 1'b1; step(); rst = 1'b0;
      chan_srq = 12'h888; step(); chan_srq = '0;
      run_service(4'd3,  48'h1111_2222_3333, 48'h1111_2222_3333, 1'b1, v);
      run_service(4'd7,  48'h4444_5555_6666, 48'h4444_5555_6666, 1'b1, v);
      run_service(4'd11, 48'h7777_8888_9999, 48'h7777_8888_9999, 1'b1, v);
      chan_srq = 12'h009; step(); chan_srq = '0;
      run_service(4'd0,  48'hDEAD_BEEF_0001, 48'hDEAD_BEEF_0001, 1'b1, v);
      run_service(4'd3,  48'h0123_4567_89AB, 48'h0123_4567_89AB, 1'b1, v);

      // masked request is retained but not serviced until unmasked
      chan_mask = 12'hFDF;
      chan_srq = 12'h020; step(); chan_srq = '0;
      check("mask_pend", 64'(pending[5]), 64'(1));
      loads = 0;
      repeat (10) begin
         if (chan_load) loads++;
         step();
      end
      check("mask_noload", 64'(loads), 64'(0));
      chan_mask = '1;
      run_service(4'd5, 48'hCAFE_F00D_5555, 48'hCAFE_F00D_5555, 1'b1, v);
      check("mask_cleared", 64'(pending[5]), 64'(0));

      // overrun counting while blocked in READY, saturation, clear priority
      chan_srq = 12'h002; step(); chan_srq = '0;
      run_service(4'd1, 48'h0F0F_0F0F_0F0F, 48'h0F0F_0F0F_0F0F, 1'b0, v);
      chan_srq = 12'h004; step(); chan_srq = '0;
      check("ovf_first", 64'(ovf_cnt), 64'(0));
      chan_srq = 12'h004; step(); chan_srq = '0;
      check("ovf_one", 64'(ovf_cnt), 64'(1));
      chan_srq = 12'h004;
      repeat (300) step();
      chan_srq = '0;
      check("ovf_sat", 64'(ovf_cnt), 64'(255));
      chan_srq = 12'h004; ovf_clr = 1'b1; step(); chan_srq = '0; ovf_clr = 1'b0;
      check("ovf_clr", 64'(ovf_cnt), 64'(0));
      check("blocked_valid", 64'(out_valid), 64'(1));
      check("blocked_pend", 64'(pending[2]), 64'(1));
      out_ack = 1'b1; step(); out_ack = 1'b0;
      run_service(4'd2, 48'h1234_5678_9ABC, 48'h1234_5678_9ABC, 1'b1, v);

      // request arriving in the same cycle its pending bit is cleared
      chan_srq = 12'h010; step();
      chan_srq = 12'h010; step(); chan_srq = '0;
      check("coll_load", 64'(chan_load), 64'(1));
      check("coll_pend", 64'(pending[4]), 64'(1));
      check("coll_ovf", 64'(ovf_cnt), 64'(0));
      run_service(4'd4, 48'hAAAA_5555_AAAA, 48'hAAAA_5555_AAAA, 1'b1, v);
      run_service(4'd4, 48'h5555_AAAA_5555, 48'h5555_AAAA_5555, 1'b1, v);
      check("coll_done", 64'(pending[4]), 64'(0));

      // reset in the middle of a readout
      chan_srq = 12'h500; step();
      chan_srq = 12'h400; step(); chan_srq = '0;
      check("pre_rst_ovf", 64'(ovf_cnt), 64'(1));
      v = 0;
      while (!chan_load && v < 10) begin
         step();
         v++;
      end
      check("rst_seq_sel", 64'(chan_sel), 64'(8));
      step();
      for (int k = 0; k < 20; k++) begin
         sin = 1'b1;
         step();
      end
      check("mid_shift", 64'(chan_shift), 64'(1));
      rst = 1'b1; step(); rst = 1'b0; sin = 1'b0;
      check("mr_shift", 64'(chan_shift), 64'(0));
      check("mr_load", 64'(chan_load), 64'(0));
      check("mr_valid", 64'(out_valid), 64'(0));
      check("mr_sel", 64'(chan_sel), 64'(0));
      check("mr_chan", 64'(out_chan), 64'(0));
      check("mr_iq", 64'(iq_data), 64'(0));
      check("mr_pending", 64'(pending), 64'(0));
      check("mr_ovf", 64'(ovf_cnt), 64'(0));
      valids = 0;
      loads = 0;
      repeat (60) begin
         if (out_valid) valids++;
         if (chan_load) loads++;
         step();
      end
      check("mr_no_valid", 64'(valids), 64'(0));
      check("mr_no_load", 64'(loads), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
